ccip_fiu_responder: RTL
=======================

Name: ccip_fiu_responder

Overview:
- Synthesizable FIU-side responder for CCI-P. It is the opposite end of the traffic the CCI-P checker sniffs: it accepts AFU read and write requests and returns C0 read responses and C1 write and fence responses.
- It replaces the real FIU in NLB bring-up and regression benches, so the checker sees protocol-legal responses with controlled latency and backpressure.
- Supports single-cacheline requests only. Read data is a deterministic function of the address, so no backing memory is needed.

Parameters:
- DEPTH, 64, entries per response FIFO (C0 and C1 each); must be a power of 2.
- ALMFULL_SLACK, 8, almost-full asserts when occupancy >= DEPTH-ALMFULL_SLACK.
- RD_LAT, 20, minimum cycles from C0 request accept to C0 response.
- WR_LAT, 12, minimum cycles from C1 request accept to C1 response.
- TS_W, 16, width of the free-running timestamp counter.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- c0_req_valid  in  1  read request strobe
- c0_req_addr  in  42  cacheline address
- c0_req_mdata  in  16  request tag
- c1_req_valid  in  1  write or fence request strobe
- c1_req_fence  in  1  1 = write fence (addr and data ignored)
- c1_req_addr  in  42  cacheline address
- c1_req_mdata  in  16  request tag
- c1_req_data  in  512  write data
- c0_almfull  out  1  C0 backpressure
- c1_almfull  out  1  C1 backpressure
- c0_rsp_valid  out  1  read response strobe
- c0_rsp_mdata  out  16  echoed tag
- c0_rsp_data  out  512  read data
- c1_rsp_valid  out  1  write or fence response strobe
- c1_rsp_fence  out  1  response is a fence ack
- c1_rsp_mdata  out  16  echoed tag
- wr_xor  out  512  running XOR of all accepted write data
- ovf_err  out  1  sticky flag: a request arrived while its FIFO was full

Behaviour:
- Reset (rst_n low, asynchronous):
  - All outputs go to 0; FIFOs empty; timestamp = 0; wr_xor = 0; ovf_err = 0.
  - A reset mid-operation discards all pending entries. No response is emitted after reset for requests accepted before it.
- Timestamp: free-running TS_W-bit counter that wraps. An entry's age is (ts - entry_ts) mod 2^TS_W.
  - RD_LAT and WR_LAT must each be < 2^(TS_W-1).
- Request accept:
  - A request is accepted on any cycle its valid is high and its FIFO is not full.
  - C0 entry stores {mdata, addr, ts}. C1 entry stores {mdata, fence, ts}.
  - valid asserted while full: the request is dropped, ovf_err is set (sticky until reset), and the FIFO is unchanged.
  - almfull is advisory only: requests are still accepted while almfull is high.
- Almost-full: c0_almfull and c1_almfull are registered, reflecting post-update occupancy >= DEPTH-ALMFULL_SLACK. They are visible the cycle after the crossing.
- Response pop:
  - Each channel pops its head when the FIFO is non-empty and head age >= LAT.
  - At most one pop per channel per cycle. Responses stay strictly in request order per channel.
  - rsp_valid is a one-cycle pulse per popped entry, registered, so the earliest response comes LAT+1 cycles after accept.
  - No response backpressure: consumers must always sink.
- C0 data: c0_rsp_data = eight copies of {22'b0, addr}, each lane 64 bits. Lane 0 is bits [63:0].
- C1 responses:
  - c1_rsp_fence = entry.fence; c1_rsp_mdata = entry.mdata.
  - A fence is acked only after every earlier C1 entry has been acked; this falls out of in-order pop.
- wr_xor: updated with c1_req_data the cycle after each accepted non-fence write. Fences and dropped writes do not change it.
- Simultaneous push and pop on the same FIFO, including when full: the pop frees a slot the same cycle.
  - Push is allowed when count == DEPTH and pop is active that cycle; occupancy is unchanged.
- Same-cycle C0 and C1 requests are independent; both are accepted.

Decomposition:
- Package ccip_resp_pkg:
  - c0_entry_t and c1_entry_t structs
  - CL_ADDR_W=42, MDATA_W=16, CL_DATA_W=512
  - function rd_pattern(addr) returning the 512-bit read pattern
- Sub-module rsp_delay_fifo, instantiated once per channel:
  - parameterized payload type, DEPTH, LAT, TS_W
  - provides push/full/almfull on the input side, and pop-eligible head plus registered valid on the output side

Test Plan:
- Single read, addr=0x1234, mdata=0x00AB, RD_LAT=20 -> one c0_rsp_valid exactly 21 cycles after accept; mdata=0x00AB; every 64-bit lane = 0x1234.
- 3 writes (mdata 1,2,3; data A, B, C), then a fence (mdata 4) on consecutive cycles -> C1 responses in order 1,2,3,4; fence flag set only on 4; wr_xor = A^B^C.
- Back-to-back reads until c0_almfull, DEPTH=64, slack 8 -> c0_almfull high the cycle after the 56th accept; 65th read while full with no pop -> ovf_err=1 and 64 responses total.
- Full FIFO with head eligible plus a new push in the same cycle -> push accepted, ovf_err stays 0, count stays 64.
- Preload timestamp near wrap (ts=0xFFF0), then read -> response still at accept+21, with no early or missed pop across the wrap.
- rst_n pulsed low with 10 reads outstanding -> all outputs 0 immediately; no c0_rsp_valid after release until new requests arrive.

Source files
------------

// File: rtl/ccip_resp_pkg.sv
// Shared types and helpers for the CCI-P FIU-side responder.
package ccip_resp_pkg;

  localparam int unsigned CL_ADDR_W = 42;
  localparam int unsigned MDATA_W   = 16;
  localparam int unsigned CL_DATA_W = 512;
  localparam int unsigned LANE_W    = 64;
  localparam int unsigned LANES     = CL_DATA_W / LANE_W;

  // Read request payload kept until its response is due
  typedef struct packed {
    logic [MDATA_W-1:0]   mdata;
    logic [CL_ADDR_W-1:0] addr;
  } c0_entry_t;

  // Write/fence request payload kept until its response is due
  typedef struct packed {
    logic [MDATA_W-1:0] mdata;
    logic               fence;
  } c1_entry_t;

  // Read data: every 64-bit lane carries the zero-extended cacheline address
  function automatic logic [CL_DATA_W-1:0] rd_pattern(input logic [CL_ADDR_W-1:0] addr);
    rd_pattern = {LANES{LANE_W'(addr)}};
  endfunction

endpackage

// File: rtl/rsp_delay_fifo.sv
// In-order FIFO that releases its head only once it has aged LAT cycles.
module rsp_delay_fifo #(
  parameter type         T             = logic,
  parameter int unsigned DEPTH         = 64,
  parameter int unsigned ALMFULL_SLACK = 8,
  parameter int unsigned LAT           = 20,
  parameter int unsigned TS_W          = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [TS_W-1:0] ts,
  input  logic            push_valid,
  input  T                push_data,
  output logic            full_c,
  output logic            push_ok_c,
  output logic            drop_c,
  output logic            almfull,
  output logic            rsp_valid,
  output T                rsp_data
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  T                mem    [DEPTH];
  logic [TS_W-1:0] ts_mem [DEPTH];
  logic [AW-1:0]   rd_ptr;
  logic [AW-1:0]   wr_ptr;
  logic [CW-1:0]   count;
  logic [CW-1:0]   count_nxt;
  logic [TS_W-1:0] head_age;
  logic            pop_c;

  // Head eligibility and push acceptance; a same-cycle pop frees a slot for the push
  always_comb begin
    head_age  = ts - ts_mem[rd_ptr];
    pop_c     = (count != '0) && (head_age >= TS_W'(LAT));
    full_c    = (count == CW'(DEPTH));
    push_ok_c = push_valid && (!full_c || pop_c);
    drop_c    = push_valid && !push_ok_c;
    count_nxt = count + CW'(push_ok_c) - CW'(pop_c);
  end

  // Payload storage; the stamp is the first cycle the entry is resident,
  // so age reaches LAT one cycle later and the registered response lands LAT+1 after accept
  always_ff @(posedge clk) begin
    if (push_ok_c) begin
      mem[wr_ptr]    <= push_data;
      ts_mem[wr_ptr] <= ts + TS_W'(1);
    end
  end

  // Pointers, occupancy, almost-full and registered response
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      almfull   <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
    end else begin
      if (push_ok_c) wr_ptr <= wr_ptr + AW'(1);
      if (pop_c)     rd_ptr <= rd_ptr + AW'(1);
      count     <= count_nxt;
      almfull   <= (count_nxt >= CW'(DEPTH - ALMFULL_SLACK));
      rsp_valid <= pop_c;
      if (pop_c) rsp_data <= mem[rd_ptr];
      else       rsp_data <= '0;
    end
  end

endmodule

// File: rtl/ccip_fiu_responder.sv
// FIU stand-in: accepts AFU C0/C1 requests and returns in-order delayed responses.
module ccip_fiu_responder
  import ccip_resp_pkg::*;
#(
  parameter int unsigned DEPTH         = 64,
  parameter int unsigned ALMFULL_SLACK = 8,
  parameter int unsigned RD_LAT        = 20,
  parameter int unsigned WR_LAT        = 12,
  parameter int unsigned TS_W          = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 c0_req_valid,
  input  logic [CL_ADDR_W-1:0] c0_req_addr,
  input  logic [MDATA_W-1:0]   c0_req_mdata,
  input  logic                 c1_req_valid,
  input  logic                 c1_req_fence,
  input  logic [CL_ADDR_W-1:0] c1_req_addr,
  input  logic [MDATA_W-1:0]   c1_req_mdata,
  input  logic [CL_DATA_W-1:0] c1_req_data,
  output logic                 c0_almfull,
  output logic                 c1_almfull,
  output logic                 c0_rsp_valid,
  output logic [MDATA_W-1:0]   c0_rsp_mdata,
  output logic [CL_DATA_W-1:0] c0_rsp_data,
  output logic                 c1_rsp_valid,
  output logic                 c1_rsp_fence,
  output logic [MDATA_W-1:0]   c1_rsp_mdata,
  output logic [CL_DATA_W-1:0] wr_xor,
  output logic                 ovf_err
);

  logic [TS_W-1:0] ts;
  c0_entry_t       c0_push;
  c0_entry_t       c0_head;
  c1_entry_t       c1_push;
  c1_entry_t       c1_head;
  logic            c0_full_c, c0_push_ok_c, c0_drop_c;
  logic            c1_full_c, c1_push_ok_c, c1_drop_c;
  logic            unused_c;

  // Write address has no bearing on the response; fullness is consumed via push_ok/drop
  assign unused_c = ^{c1_req_addr, c0_full_c, c1_full_c};

  assign c0_push = '{mdata: c0_req_mdata, addr: c0_req_addr};
  assign c1_push = '{mdata: c1_req_mdata, fence: c1_req_fence};

  // Free-running timestamp used to age entries
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ts <= '0;
    else        ts <= ts + TS_W'(1);
  end

  rsp_delay_fifo #(
    .T             (c0_entry_t),
    .DEPTH         (DEPTH),
    .ALMFULL_SLACK (ALMFULL_SLACK),
    .LAT           (RD_LAT),
    .TS_W          (TS_W)
  ) u_c0_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .ts         (ts),
    .push_valid (c0_req_valid),
    .push_data  (c0_push),
    .full_c     (c0_full_c),
    .push_ok_c  (c0_push_ok_c),
    .drop_c     (c0_drop_c),
    .almfull    (c0_almfull),
    .rsp_valid  (c0_rsp_valid),
    .rsp_data   (c0_head)
  );

  rsp_delay_fifo #(
    .T             (c1_entry_t),
    .DEPTH         (DEPTH),
    .ALMFULL_SLACK (ALMFULL_SLACK),
    .LAT           (WR_LAT),
    .TS_W          (TS_W)
  ) u_c1_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .ts         (ts),
    .push_valid (c1_req_valid),
    .push_data  (c1_push),
    .full_c     (c1_full_c),
    .push_ok_c  (c1_push_ok_c),
    .drop_c     (c1_drop_c),
    .almfull    (c1_almfull),
    .rsp_valid  (c1_rsp_valid),
    .rsp_data   (c1_head)
  );

  // Response fields are straight wiring of the registered head (zero when idle)
  assign c0_rsp_mdata = c0_head.mdata;
  assign c0_rsp_data  = rd_pattern(c0_head.addr);
  assign c1_rsp_fence = c1_head.fence;
  assign c1_rsp_mdata = c1_head.mdata;

  // Write-data signature and sticky overflow flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_xor  <= '0;
      ovf_err <= 1'b0;
    end else begin
      if (c1_push_ok_c && !c1_req_fence) wr_xor <= wr_xor ^ c1_req_data;
      if (c0_drop_c || c1_drop_c)        ovf_err <= 1'b1;
    end
  end

endmodule
